io_mem_bank: RTL and testbench
==============================

Name: io_mem_bank

Overview:
- Parametrised memory-mapped I/O slave for the pipeline computer's data-memory bus.
- Drives NUM_HEX active-low seven-segment digits (as decimal pairs) and LED_W LEDs, and reads SW_W switches.
- New over the previous generation:
  - switch synchronisation and debounce;
  - sticky switch-change flags with write-1-to-clear;
  - LED set/clear ports;
  - per-pair hex blanking;
  - read-back of all output registers;
  - unmapped writes are ignored.

Parameters:
- NUM_HEX, 6, number of seven-seg digits; must be even, 2..8.
- LED_W, 10, LED count, 1..32.
- SW_W, 10, switch count, 1..32.
- DB_TICK, 50000, clock cycles between debounce samples; must be ≥2.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  synchronous, active-high.
- addr  in  5  word address.
- data_in  in  32  write data.
- write_enable  in  1  write strobe, sampled at posedge.
- data_out  out  32  registered read data.
- io_in_sw  in  SW_W  raw asynchronous switches.
- io_out_led  out  LED_W  LED drive, 1 = lit.
- io_out_hex  out  7*NUM_HEX  active-low segments; digit k occupies bits [7k+6:7k].

Behaviour:
- Reset values (sync reset): data_out=0, io_out_led=0, io_out_hex all 1 (blank), hex value regs=0, blank mask all 1, sync/debounce regs=0, debounced switches=0, change flags=0, tick counter=0.
- Address map:
  - 0..NUM_HEX/2-1 HEXn: pair n (digits 2n, 2n+1).
    - Write: stores data_in[6:0].
    - Read: {25'b0, stored}.
  - 8 LED: write loads data_in[LED_W-1:0]; read returns LED reg.
  - 9 LED_SET: write ORs data_in into LED; read returns 0.
  - 10 LED_CLR: write ANDs ~data_in into LED; read returns 0.
  - 11 HEX_BLANK: bit n=1 blanks pair n. Write loads data_in[NUM_HEX/2-1:0]; read returns the mask.
  - 12 SW: read-only, debounced switches, zero-extended.
  - 13 SW_CHG: read returns sticky flags; write clears each flag whose data_in bit is 1 (W1C).
  - 14 ID: read-only, {8'hA5, 8'(NUM_HEX), 8'(LED_W), 8'(SW_W)}.
- Writes to unmapped or read-only addresses: no effect. Reads of unmapped addresses: 0.
- Read latency: data_out updates at the posedge where addr is presented; valid one cycle later, independent of write_enable.
- Read-during-write to the same register returns the pre-write value.
- Hex decode: io_out_hex is a combinational decode of registered state only, so it changes right after the write edge.
  - Value v 0..99: high digit = v/10, low digit = v%10; low digit on digit 2n, high digit on digit 2n+1; standard active-low patterns.
  - Value 100..127: both digits show "-" (segment g only lit, 7'b0111111).
  - Blank mask bit set: both digits 7'h7F.
- Switch path:
  - 2-FF synchroniser per bit.
  - A shared tick fires every DB_TICK cycles (counter wraps DB_TICK-1 → 0).
  - On each tick, sample the synchronised bits. The debounced bit takes the new sample only if it equals the previous tick's sample.
  - Latency from a stable change to the debounced update: 2 + 1 to 2 ticks.
- Change flags:
  - A flag bit sets when its debounced bit changes (either edge).
  - If a W1C clear and a new change on the same bit fall in the same cycle, set wins.
  - Flags stay set until cleared.
- LED_SET and LED_CLR act on the current register value; there is only one write port, so at most one LED op per cycle.
- Reset asserted mid-debounce: counters and samples return to 0 and io_out_hex blanks within the same edge.

Decomposition:
- Package io_mem_pkg:
  - address localparams: A_HEX0, A_LED, A_LED_SET, A_LED_CLR, A_HEX_BLANK, A_SW, A_SW_CHG, A_ID;
  - ID byte 8'hA5;
  - 7-bit segment constants SEG_BLANK and SEG_DASH.
- Reuse the existing sevenseg digit decoder, one instance per digit.
- One new sub-module, io_debounce #(W, DB_TICK): synchroniser, tick counter, two-sample agreement and change pulse. Outputs the debounced vector plus a per-bit change strobe.

Test Plan:
- Reset, then read addr 14 → data_out=32'hA5060A0A one cycle later. Check io_out_hex all 1 and io_out_led=0.
- Write 42 to addr 0 → digit0=seg(2), digit1=seg(4). Write 100 to addr 1 → digits 2,3 = 7'b0111111. Write 11 = 3'b001 → pair 0 = 7'h7F, pair 1 unaffected. Read addr 0 → 42.
- LED ops:
  - write 10'h0F0 to addr 8;
  - write 10'h003 to addr 9 → 10'h0F3;
  - write 10'h030 to addr 10 → 10'h0C3;
  - read addr 8 → 32'h0C3.
- With DB_TICK=4:
  - hold io_in_sw=10'h001 steady → addr 12 reads 1 within 2+8 cycles, addr 13 reads 1;
  - a 3-cycle glitch to 10'h002 → no change to SW or flags.
- Flags set and cleared:
  - write 1 to addr 13 → reads 0 next;
  - W1C of bit 0 in the same cycle as a new bit-0 debounced change → flag remains 1.
- Write to addr 20 and addr 12 → no state changes; read addr 20 → 0. Assert reset mid-operation → all outputs return to reset values after that edge.

Source files
------------

// File: rtl/io_mem_bank_pkg.sv
// io_mem_pkg: shared constants for the I/O memory bank.
//   - Word addresses of every register on the data-memory bus.
//   - ID signature byte.
//   - Segment patterns for blank and dash (active-low, bit 6 = g ... bit 0 = a).
package io_mem_pkg;

  localparam logic [4:0] A_HEX0      = 5'd0;
  localparam logic [4:0] A_LED       = 5'd8;
  localparam logic [4:0] A_LED_SET   = 5'd9;
  localparam logic [4:0] A_LED_CLR   = 5'd10;
  localparam logic [4:0] A_HEX_BLANK = 5'd11;
  localparam logic [4:0] A_SW        = 5'd12;
  localparam logic [4:0] A_SW_CHG    = 5'd13;
  localparam logic [4:0] A_ID        = 5'd14;

  localparam logic [7:0] ID_BYTE = 8'hA5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

// File: rtl/io_mem_bank_if.sv
// io_mem_bank_if: data-memory bus between the pipeline core and the I/O bank.
//   addr         5-bit word address
//   data_in      32-bit write data
//   write_enable write strobe, sampled at posedge
//   data_out     32-bit registered read data
interface io_mem_bank_if;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;

  modport master (output addr, data_in, write_enable, input data_out);
  modport slave  (input addr, data_in, write_enable, output data_out);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: switch synchroniser and tick-based debouncer.
//   clock, reset  system clock, synchronous active-high reset
//   raw           asynchronous switch inputs
//   db            debounced switch vector
//   chg           one-cycle strobe per bit, high on the edge db[i] toggles
// A shared counter fires a tick every DB_TICK cycles. On a tick each bit is
// sampled; the debounced bit only follows when two consecutive tick samples
// agree, so a glitch shorter than one tick period is never accepted.
module io_debounce #(
  parameter int W       = 10,
  parameter int DB_TICK = 50000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] db,
  output logic [W-1:0] chg
);
  localparam int CW = (DB_TICK > 2) ? $clog2(DB_TICK) : 1;

  logic [CW-1:0] cnt;
  logic [W-1:0]  s1, s2, samp;
  logic          tick;

  assign tick = (cnt == CW'(DB_TICK - 1));
  // Toggle where the new sample agrees with the last one and differs from db.
  assign chg  = tick ? (~(s2 ^ samp) & (s2 ^ db)) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      s1   <= '0;
      s2   <= '0;
      samp <= '0;
      db   <= '0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) begin
        samp <= s2;
        db   <= db ^ chg;
      end
    end
  end
endmodule

// File: rtl/sevenseg.sv
// sevenseg: decimal digit to active-low seven-segment pattern.
//   digit  4-bit value; anything above 9 shows blank
//   seg    segments {g,f,e,d,c,b,a}, 0 = lit
module sevenseg (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/io_mem_bank.sv
// io_mem_bank: memory-mapped I/O slave on the data-memory bus.
//   clock, reset  system clock, synchronous active-high reset
//   bus           slave side of io_mem_bank_if (addr/data_in/write_enable/data_out)
//   io_in_sw      raw switches (debounced internally)
//   io_out_led    LED drive, 1 = lit
//   io_out_hex    active-low segments, digit k at [7k+6:7k]
// Each hex pair holds a 7-bit value shown as two decimal digits (low digit on
// the even digit). Values 100..127 show dashes; a set blank bit darkens the pair.
// data_out is registered from addr every cycle, so a read in the same cycle as
// a write returns the pre-write value.
module io_mem_bank
  import io_mem_pkg::*;
#(
  parameter int NUM_HEX = 6,   // even, 2..8
  parameter int LED_W   = 10,  // 1..32
  parameter int SW_W    = 10,  // 1..32
  parameter int DB_TICK = 50000
) (
  input  logic                 clock,
  input  logic                 reset,
  io_mem_bank_if.slave         bus,
  input  logic [SW_W-1:0]      io_in_sw,
  output logic [LED_W-1:0]     io_out_led,
  output logic [7*NUM_HEX-1:0] io_out_hex
);
  localparam int NPAIR = NUM_HEX / 2;

  logic [NPAIR-1:0][6:0] hex_val;
  logic [NPAIR-1:0]      blank;
  logic [SW_W-1:0]       sw_db, sw_chg_pulse, sw_chg, sw_clr;
  logic [31:0]           rdata;
  logic                  unused_data_in;

  // Not every data_in bit maps to a register for narrow configurations.
  assign unused_data_in = ^bus.data_in;

  io_debounce #(.W(SW_W), .DB_TICK(DB_TICK)) u_db (
    .clock (clock),
    .reset (reset),
    .raw   (io_in_sw),
    .db    (sw_db),
    .chg   (sw_chg_pulse)
  );

  assign sw_clr = (bus.write_enable && bus.addr == A_SW_CHG) ? bus.data_in[SW_W-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      hex_val      <= '0;
      blank        <= '1;
      io_out_led   <= '0;
      sw_chg       <= '0;
      bus.data_out <= '0;
    end else begin
      bus.data_out <= rdata;
      // New change is OR-ed after the clear so a simultaneous set wins.
      sw_chg <= (sw_chg & ~sw_clr) | sw_chg_pulse;
      if (bus.write_enable) begin
        for (int n = 0; n < NPAIR; n++)
          if (bus.addr == 5'(A_HEX0 + 5'(n))) hex_val[n] <= bus.data_in[6:0];
        case (bus.addr)
          A_LED:       io_out_led <= bus.data_in[LED_W-1:0];
          A_LED_SET:   io_out_led <= io_out_led | bus.data_in[LED_W-1:0];
          A_LED_CLR:   io_out_led <= io_out_led & ~bus.data_in[LED_W-1:0];
          A_HEX_BLANK: blank      <= bus.data_in[NPAIR-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int n = 0; n < NPAIR; n++)
      if (bus.addr == 5'(A_HEX0 + 5'(n))) rdata = {25'b0, hex_val[n]};
    case (bus.addr)
      A_LED:       rdata = 32'(io_out_led);
      A_HEX_BLANK: rdata = 32'(blank);
      A_SW:        rdata = 32'(sw_db);
      A_SW_CHG:    rdata = 32'(sw_chg);
      A_ID:        rdata = {ID_BYTE, 8'(NUM_HEX), 8'(LED_W), 8'(SW_W)};
      default: ;
    endcase
  end

  for (genvar n = 0; n < NPAIR; n++) begin : g_pair
    logic [3:0] lo_d, hi_d;
    logic [6:0] lo_s, hi_s;

    assign lo_d = 4'(hex_val[n] % 7'd10);
    assign hi_d = 4'(hex_val[n] / 7'd10);

    sevenseg u_lo (.digit(lo_d), .seg(lo_s));
    sevenseg u_hi (.digit(hi_d), .seg(hi_s));

    assign io_out_hex[14*n +: 14] = blank[n]             ? {SEG_BLANK, SEG_BLANK} :
                                    (hex_val[n] > 7'd99) ? {SEG_DASH, SEG_DASH}   :
                                                           {hi_s, lo_s};
  end
endmodule

// File: tb/tb_io_mem_bank.sv
// tb_io_mem_bank: scoreboard bench for io_mem_bank with a short debounce tick.
module tb_io_mem_bank;
  localparam int NUM_HEX = 6, LED_W = 10, SW_W = 10, DB_TICK = 4;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [SW_W-1:0]      io_in_sw = '0;
  logic [LED_W-1:0]     io_out_led;
  logic [7*NUM_HEX-1:0] io_out_hex;

  io_mem_bank_if bus();

  io_mem_bank #(.NUM_HEX(NUM_HEX), .LED_W(LED_W), .SW_W(SW_W), .DB_TICK(DB_TICK)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .io_in_sw   (io_in_sw),
    .io_out_led (io_out_led),
    .io_out_hex (io_out_hex)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  // Reference debounce timing, used to place a clear on the exact change edge.
  logic [SW_W-1:0] m_s1, m_s2, m_samp, m_db;
  int m_cnt;
  always @(posedge clock) begin
    if (reset) begin
      m_s1 <= '0; m_s2 <= '0; m_samp <= '0; m_db <= '0; m_cnt <= 0;
    end else begin
      m_s1 <= io_in_sw;
      m_s2 <= m_s1;
      m_cnt <= (m_cnt == DB_TICK - 1) ? 0 : m_cnt + 1;
      if (m_cnt == DB_TICK - 1) begin
        m_samp <= m_s2;
        for (int i = 0; i < SW_W; i++)
          if (m_s2[i] == m_samp[i]) m_db[i] <= m_s2[i];
      end
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.addr = a; bus.data_in = d; bus.write_enable = 1'b1;
    cyc();
    bus.write_enable = 1'b0;
  endtask

  // Issue a read and queue what it must return; the result is valid on return.
  task automatic rd(input logic [4:0] a, input logic [31:0] exp_v);
    bus.addr = a; bus.write_enable = 1'b0;
    exp_q.push_back(exp_v);
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) cyc();
    checks++; if (io_out_hex !== '1) begin failures++; $display("FAIL rst_hex got=%h exp=all-ones", io_out_hex); end
    checks++; if (io_out_led !== '0) begin failures++; $display("FAIL rst_led got=%h exp=0", io_out_led); end
    checks++; if (bus.data_out !== 32'h0) begin failures++; $display("FAIL rst_dout got=%h exp=0", bus.data_out); end
    reset = 1'b0;
    rd(5'd14, 32'hA506_0A0A);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_id got=%h exp=%h", bus.data_out, e); end
  endtask

  task automatic test_hex();
    wr(5'd11, 32'h0);
    wr(5'd0, 32'd42);
    checks++; if (io_out_hex[6:0] !== 7'h24) begin failures++; $display("FAIL hex_d0 got=%h exp=24", io_out_hex[6:0]); end
    checks++; if (io_out_hex[13:7] !== 7'h19) begin failures++; $display("FAIL hex_d1 got=%h exp=19", io_out_hex[13:7]); end
    wr(5'd1, 32'd100);
    checks++; if (io_out_hex[27:14] !== {7'h3F, 7'h3F}) begin failures++; $display("FAIL hex_dash got=%h exp=1fbf", io_out_hex[27:14]); end
    checks++; if (io_out_hex[41:28] !== {7'h40, 7'h40}) begin failures++; $display("FAIL hex_zero got=%h exp=2040", io_out_hex[41:28]); end
    wr(5'd11, 32'h1);
    checks++; if (io_out_hex[13:0] !== {7'h7F, 7'h7F}) begin failures++; $display("FAIL hex_blank got=%h exp=3fff", io_out_hex[13:0]); end
    checks++; if (io_out_hex[27:14] !== {7'h3F, 7'h3F}) begin failures++; $display("FAIL hex_pair1_kept got=%h exp=1fbf", io_out_hex[27:14]); end
    rd(5'd0, 32'd42);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_hex0 got=%h exp=%h", bus.data_out, e); end
    rd(5'd1, 32'd100);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_hex1 got=%h exp=%h", bus.data_out, e); end
    rd(5'd11, 32'h1);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_blank got=%h exp=%h", bus.data_out, e); end
  endtask

  task automatic test_led();
    wr(5'd8, 32'h0F0);
    checks++; if (io_out_led !== 10'h0F0) begin failures++; $display("FAIL led_load got=%h exp=0f0", io_out_led); end
    wr(5'd9, 32'h003);
    checks++; if (io_out_led !== 10'h0F3) begin failures++; $display("FAIL led_set got=%h exp=0f3", io_out_led); end
    wr(5'd10, 32'h030);
    checks++; if (io_out_led !== 10'h0C3) begin failures++; $display("FAIL led_clr got=%h exp=0c3", io_out_led); end
    rd(5'd8, 32'h0C3);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_led got=%h exp=%h", bus.data_out, e); end
    rd(5'd9, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_led_set got=%h exp=%h", bus.data_out, e); end
    // Read during write to the same register returns the old value.
    exp_q.push_back(32'h0C3);
    wr(5'd8, 32'h155);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_during_wr got=%h exp=%h", bus.data_out, e); end
    checks++; if (io_out_led !== 10'h155) begin failures++; $display("FAIL led_after_rdw got=%h exp=155", io_out_led); end
  endtask

  task automatic test_debounce();
    logic found = 1'b0;
    io_in_sw = 10'h001;
    bus.addr = 5'd12; bus.write_enable = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      cyc();
      if (bus.data_out === 32'h1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL sw_settle got=%h exp=1 within 16 cycles", bus.data_out); end
    rd(5'd13, 32'h1);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL chg_set got=%h exp=%h", bus.data_out, e); end
    wr(5'd13, 32'h1);
    rd(5'd13, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL chg_w1c got=%h exp=%h", bus.data_out, e); end
    // Glitch shorter than one tick period must be rejected.
    io_in_sw = 10'h002;
    repeat (3) cyc();
    io_in_sw = 10'h001;
    repeat (16) cyc();
    rd(5'd12, 32'h1);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL glitch_sw got=%h exp=%h", bus.data_out, e); end
    rd(5'd13, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL glitch_chg got=%h exp=%h", bus.data_out, e); end
  endtask

  task automatic test_w1c_race();
    logic found = 1'b0;
    io_in_sw = 10'h000;
    for (int i = 0; i < 24 && !found; i++) begin
      if (m_cnt == DB_TICK - 1 && m_s2[0] == m_samp[0] && m_s2[0] != m_db[0]) begin
        wr(5'd13, 32'h1);
        found = 1'b1;
      end else cyc();
    end
    checks++; if (!found) begin failures++; $display("FAIL race_edge got=none exp=change edge within 24 cycles"); end
    rd(5'd13, 32'h1);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL race_set_wins got=%h exp=%h", bus.data_out, e); end
    rd(5'd12, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL race_sw got=%h exp=%h", bus.data_out, e); end
  endtask

  task automatic test_unmapped();
    logic [NUM_HEX-1:0][6:0] ex;
    ex = {7'h40, 7'h40, 7'h3F, 7'h3F, 7'h7F, 7'h7F};
    wr(5'd20, 32'hFFFF_FFFF);
    wr(5'd12, 32'hFFFF_FFFF);
    wr(5'd3,  32'hFFFF_FFFF);
    wr(5'd14, 32'h0);
    checks++; if (io_out_led !== 10'h155) begin failures++; $display("FAIL unm_led got=%h exp=155", io_out_led); end
    checks++; if (io_out_hex !== ex) begin failures++; $display("FAIL unm_hex got=%h exp=%h", io_out_hex, ex); end
    rd(5'd20, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_unm20 got=%h exp=%h", bus.data_out, e); end
    rd(5'd3, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_unm3 got=%h exp=%h", bus.data_out, e); end
    rd(5'd13, 32'h1);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL unm_flags got=%h exp=%h", bus.data_out, e); end
    rd(5'd14, 32'hA506_0A0A);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL rd_id_ro got=%h exp=%h", bus.data_out, e); end
  endtask

  task automatic test_reset_mid();
    io_in_sw = 10'h3FF;
    bus.addr = 5'd14;
    repeat (5) cyc();
    reset = 1'b1;
    cyc();
    checks++; if (io_out_hex !== '1) begin failures++; $display("FAIL mid_rst_hex got=%h exp=all-ones", io_out_hex); end
    checks++; if (io_out_led !== '0) begin failures++; $display("FAIL mid_rst_led got=%h exp=0", io_out_led); end
    checks++; if (bus.data_out !== 32'h0) begin failures++; $display("FAIL mid_rst_dout got=%h exp=0", bus.data_out); end
    reset = 1'b0;
    rd(5'd12, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL mid_rst_sw got=%h exp=%h", bus.data_out, e); end
    rd(5'd13, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL mid_rst_chg got=%h exp=%h", bus.data_out, e); end
    rd(5'd11, 32'h7);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL mid_rst_mask got=%h exp=%h", bus.data_out, e); end
    rd(5'd0, 32'h0);
    e = exp_q.pop_front();
    checks++; if (bus.data_out !== e) begin failures++; $display("FAIL mid_rst_hexval got=%h exp=%h", bus.data_out, e); end
  endtask

  initial begin
    bus.addr = '0; bus.data_in = '0; bus.write_enable = 1'b0;
    test_reset();
    test_hex();
    test_led();
    test_debounce();
    test_w1c_race();
    test_unmapped();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
